// File: rtl/key_debounce_encoder.sv
// key_debounce_encoder: synchronizes, debounces and encodes active-low keys
// into a 4-bit digit with single-cycle digit_valid / multi_err strobes.
// Optional key-click output 'beep' is built only when KEY_BEEP_EN is defined.
module key_debounce_encoder #(
   parameter int unsigned NUM_KEYS        = 10,
   parameter int unsigned DEBOUNCE_CYCLES = 1024,
   parameter int unsigned BEEP_CYCLES     = 4096
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key,
   input  logic                enable,
   output logic [3:0]          digit,
   output logic                digit_valid,
   output logic                multi_err,
   output logic                key_busy
`ifdef KEY_BEEP_EN
   ,
   output logic                beep
`endif
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [NUM_KEYS-1:0] ALL_ONE = '1;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DEB_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      DEB_RELEASE = 2'd3
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [NUM_KEYS-1:0] snapshot;
   logic [NUM_KEYS-1:0] sync1;
   logic [NUM_KEYS-1:0] ks;
   logic [4:0]          low_cnt;
   logic [3:0]          low_idx;

   // Two-flop synchronizer; idle level is all-ones (no key pressed)
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '1;
         ks    <= '1;
      end else begin
         sync1 <= key;
         ks    <= sync1;
      end
   end

   // Count low bits of the synchronized keys and locate the (last) low one
   always_comb begin
      low_cnt = '0;
      low_idx = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (!ks[i]) begin
            low_cnt = low_cnt + 5'd1;
            low_idx = 4'(i);
         end
      end
   end

   // Press/release debounce FSM with registered strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         snapshot    <= '1;
         digit       <= '0;
         digit_valid <= 1'b0;
         multi_err   <= 1'b0;
      end else begin
         digit_valid <= 1'b0;
         multi_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (ks != ALL_ONE && enable) begin
                  state    <= DEB_PRESS;
                  snapshot <= ks;
                  cnt      <= '0;
               end
            end
            DEB_PRESS: begin
               if (ks == ALL_ONE) begin
                  state <= IDLE;
               end else if (ks != snapshot) begin
                  snapshot <= ks;
                  cnt      <= '0;
               end else if (!enable) begin
                  state <= PRESSED;
               end else if (cnt == CNT_MAX) begin
                  state <= PRESSED;
                  if (low_cnt == 5'd1) begin
                     digit       <= low_idx;
                     digit_valid <= 1'b1;
                  end else begin
                     multi_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            PRESSED: begin
               if (ks == ALL_ONE) begin
                  state <= DEB_RELEASE;
                  cnt   <= '0;
               end
            end
            DEB_RELEASE: begin
               if (ks != ALL_ONE) begin
                  state <= PRESSED;
               end else if (cnt == CNT_MAX) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign key_busy = (state != IDLE);

`ifdef KEY_BEEP_EN
   localparam int unsigned BEEP_W = $clog2(2 * BEEP_CYCLES);

   logic              done_c;
   logic              accept_c;
   logic              err_c;
   logic [BEEP_W-1:0] beep_cnt;

   // Same-edge copies of the strobe conditions so beep falls with the strobe
   always_comb begin
      done_c   = (state == DEB_PRESS) && (ks != ALL_ONE) && (ks == snapshot)
                 && enable && (cnt == CNT_MAX);
      accept_c = done_c && (low_cnt == 5'd1);
      err_c    = done_c && (low_cnt != 5'd1);
   end

   // Click timer: BEEP_CYCLES on a digit, twice that on a multi-key error
   always_ff @(posedge clk) begin
      if (rst) begin
         beep     <= 1'b1;
         beep_cnt <= '0;
      end else if (accept_c) begin
         beep     <= 1'b0;
         beep_cnt <= BEEP_W'(BEEP_CYCLES - 1);
      end else if (err_c) begin
         beep     <= 1'b0;
         beep_cnt <= BEEP_W'(2 * BEEP_CYCLES - 1);
      end else if (beep_cnt != '0) begin
         beep_cnt <= beep_cnt - BEEP_W'(1);
      end else begin
         beep <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_key_debounce_encoder.sv
// Directed bench for key_debounce_encoder (DEBOUNCE_CYCLES=8, BEEP_CYCLES=16).
module tb_key_debounce_encoder;

   localparam int unsigned NK = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic [NK-1:0] key;
   logic          enable;
   logic [3:0]    digit;
   logic          digit_valid;
   logic          multi_err;
   logic          key_busy;
`ifdef KEY_BEEP_EN
   logic          beep;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int dv_cnt = 0, me_cnt = 0, both_cnt = 0, last_dv_cyc = 0;
   int beep_low = 0, beep_fall_cyc = 0;
   logic beep_prev = 1'b1;

   key_debounce_encoder #(
      .NUM_KEYS(NK), .DEBOUNCE_CYCLES(8), .BEEP_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst), .key(key), .enable(enable),
      .digit(digit), .digit_valid(digit_valid), .multi_err(multi_err),
      .key_busy(key_busy)
`ifdef KEY_BEEP_EN
      , .beep(beep)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor sampled on the falling edge
   always @(negedge clk) begin
      if (digit_valid === 1'b1) begin
         dv_cnt      <= dv_cnt + 1;
         last_dv_cyc <= cyc;
      end
      if (multi_err === 1'b1) me_cnt <= me_cnt + 1;
      if (digit_valid === 1'b1 && multi_err === 1'b1) both_cnt <= both_cnt + 1;
`ifdef KEY_BEEP_EN
      if (beep === 1'b0) beep_low <= beep_low + 1;
      if (beep === 1'b0 && beep_prev === 1'b1) beep_fall_cyc <= cyc;
      beep_prev <= beep;
`endif
   end

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int t0, dv0, me0, bl0;

   initial begin
      rst = 1'b1; key = '1; enable = 1'b1;
      step(2);
      check("rst_digit", int'(digit), 0);
      check("rst_dv", int'(digit_valid), 0);
      check("rst_me", int'(multi_err), 0);
      check("rst_busy", int'(key_busy), 0);
`ifdef KEY_BEEP_EN
      check("rst_beep", int'(beep), 1);
`endif
      rst = 1'b0;
      step(2);

      // Clean press of key 3, held 40 cycles
      dv0 = dv_cnt; key[3] = 1'b0; t0 = cyc;
      step(40);
      check("k3_count", dv_cnt - dv0, 1);
      check("k3_latency", last_dv_cyc - t0, 11);
      check("k3_digit", int'(digit), 3);
      check("k3_busy_held", int'(key_busy), 1);
      key = '1;
      step(10);
      check("k3_busy_rel10", int'(key_busy), 1);
      step(1);
      check("k3_busy_rel11", int'(key_busy), 0);
      step(4);

      // Bouncing key 5, then held
      dv0 = dv_cnt;
      for (int i = 0; i < 10; i++) begin
         key[5] = 1'(i % 2);
         step(3);
      end
      check("k5_bounce_quiet", dv_cnt - dv0, 0);
      key[5] = 1'b0; t0 = cyc;
      step(20);
      check("k5_count", dv_cnt - dv0, 1);
      check("k5_latency", last_dv_cyc - t0, 11);
      check("k5_digit", int'(digit), 5);
      key = '1;
      step(15);

      // Two keys low -> multi_err only
      dv0 = dv_cnt; me0 = me_cnt;
      key[1] = 1'b0; key[2] = 1'b0;
      step(20);
      check("multi_me", me_cnt - me0, 1);
      check("multi_dv", dv_cnt - dv0, 0);
      check("multi_digit", int'(digit), 5);
      key = '1;
      step(15);

      // Press while disabled is ignored in IDLE
      dv0 = dv_cnt; enable = 1'b0; key[6] = 1'b0;
      step(12);
      check("dis_busy", int'(key_busy), 0);
      check("dis_dv", dv_cnt - dv0, 0);
      key = '1; enable = 1'b1;
      step(4);

      // Enable drops mid-debounce: press suppressed, held key never fires
      dv0 = dv_cnt; key[7] = 1'b0;
      step(5);
      enable = 1'b0;
      step(10);
      check("k7_busy_sup", int'(key_busy), 1);
      enable = 1'b1;
      step(20);
      check("k7_suppressed", dv_cnt - dv0, 0);
      key = '1;
      step(15);
      check("k7_idle", int'(key_busy), 0);
      key[7] = 1'b0; t0 = cyc;
      step(20);
      check("k7_count", dv_cnt - dv0, 1);
      check("k7_latency", last_dv_cyc - t0, 11);
      check("k7_digit", int'(digit), 7);
      key = '1;
      step(15);

      // Reset during DEB_PRESS with key 9 held
      dv0 = dv_cnt; key[9] = 1'b0;
      step(7);
      rst = 1'b1;
      step(1);
      rst = 1'b0; t0 = cyc;
      check("k9_rst_busy", int'(key_busy), 0);
      check("k9_rst_digit", int'(digit), 0);
      check("k9_no_early", dv_cnt - dv0, 0);
      step(20);
      check("k9_count", dv_cnt - dv0, 1);
      check("k9_latency", last_dv_cyc - t0, 11);
      check("k9_digit", int'(digit), 9);
      key = '1;
      step(15);

`ifdef KEY_BEEP_EN
      // Key 0 click length
      step(40);
      dv0 = dv_cnt; bl0 = beep_low; key[0] = 1'b0;
      step(40);
      check("k0_digit", int'(digit), 0);
      check("k0_count", dv_cnt - dv0, 1);
      check("beep_len", beep_low - bl0, 16);
      check("beep_start", beep_fall_cyc, last_dv_cyc);
      key = '1;
      step(15);
`endif

      check("no_overlap", both_cnt, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
